// File: rtl/fuji_timing_generator.sv
// 14.31818 MHz tick generator with derived phi0/Q3/7M strobes and a per-line CPU cycle counter.
// Optional FUJI_TIMING_STRETCH_EN makes the last cycle of each line two ticks longer.
module fuji_timing_generator #(
    parameter int ACC_WIDTH       = 32,
    parameter logic [ACC_WIDTH-1:0] PHASE_INC = ACC_WIDTH'(614961048),
    parameter int CYCLES_PER_LINE = 65
) (
    input  logic       clk_core,
    input  logic       reset,
    input  logic [1:0] speed,
    output logic       ce_14m,
    output logic       ce_7m,
    output logic       ce_phi0_rise,
    output logic       ce_phi1_rise,
    output logic       phi0,
    output logic       q3,
    output logic [6:0] hcount
);

    localparam logic [6:0] LAST_H = 7'(CYCLES_PER_LINE - 1);

    logic [ACC_WIDTH-1:0] acc_reg;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [ACC_WIDTH-1:0] step;
    logic [ACC_WIDTH:0]   sum;
    logic                 tick_event;

    logic [3:0] tick_reg, tick_next;
    logic [3:0] last_tick;
    logic [3:0] half_offset;
    logic [6:0] hcount_reg, hcount_next;
    logic       phi0_reg, phi0_next;
    logic       q3_reg, q3_next;
    logic       ce_14m_reg, ce_7m_reg, ce_phi0_rise_reg, ce_phi1_rise_reg;
    logic       wrap;

    always_comb begin
        step = PHASE_INC;
        case (speed)
            2'b01:   step = PHASE_INC << 1;
            2'b10:   step = '0;
            default: step = PHASE_INC;
        endcase
        sum        = {1'b0, acc_reg} + {1'b0, step};
        acc_next   = sum[ACC_WIDTH-1:0];
        tick_event = sum[ACC_WIDTH];
    end

`ifdef FUJI_TIMING_STRETCH_EN
    assign last_tick = (hcount_reg == LAST_H) ? 4'd15 : 4'd13;
`else
    assign last_tick = 4'd13;
`endif

    always_comb begin
        wrap        = tick_event && (tick_reg == last_tick);
        tick_next   = tick_reg;
        hcount_next = hcount_reg;
        if (tick_event) begin
            tick_next = wrap ? 4'd0 : tick_reg + 4'd1;
        end
        if (wrap) begin
            hcount_next = (hcount_reg == LAST_H) ? 7'd0 : hcount_reg + 7'd1;
        end
        // Q3 repeats its 4-high/3-low shape in both phi0 halves; stretch ticks stay low.
        half_offset = (tick_next < 4'd7) ? tick_next : tick_next - 4'd7;
        phi0_next   = (tick_next < 4'd7);
        q3_next     = (half_offset < 4'd4);
    end

    always_ff @(posedge clk_core) begin
        if (reset) begin
            acc_reg          <= '0;
            tick_reg         <= 4'd0;
            hcount_reg       <= 7'd0;
            phi0_reg         <= 1'b1;
            q3_reg           <= 1'b1;
            ce_14m_reg       <= 1'b0;
            ce_7m_reg        <= 1'b0;
            ce_phi0_rise_reg <= 1'b0;
            ce_phi1_rise_reg <= 1'b0;
        end else begin
            acc_reg          <= acc_next;
            tick_reg         <= tick_next;
            hcount_reg       <= hcount_next;
            phi0_reg         <= phi0_next;
            q3_reg           <= q3_next;
            ce_14m_reg       <= tick_event;
            ce_7m_reg        <= tick_event && !tick_next[0];
            ce_phi0_rise_reg <= wrap;
            ce_phi1_rise_reg <= tick_event && (tick_next == 4'd7);
        end
    end

    assign ce_14m       = ce_14m_reg;
    assign ce_7m        = ce_7m_reg;
    assign ce_phi0_rise = ce_phi0_rise_reg;
    assign ce_phi1_rise = ce_phi1_rise_reg;
    assign phi0         = phi0_reg;
    assign q3           = q3_reg;
    assign hcount       = hcount_reg;

endmodule

// File: tb/tb_fuji_timing_generator.sv
// Scoreboard bench for fuji_timing_generator: expected tick records are queued by the
// stimulus and popped by a monitor on every ce_14m pulse.
module tb_fuji_timing_generator;

    localparam int          ACC_WIDTH = 32;
    localparam longint      PHASE_INC = 614961048;
    localparam int          CPL       = 65;
`ifdef FUJI_TIMING_STRETCH_EN
    localparam int          LINE_TICKS = 14 * CPL + 2;
`else
    localparam int          LINE_TICKS = 14 * CPL;
`endif

    logic       clk_core = 1'b0;
    logic       reset;
    logic [1:0] speed;
    logic       ce_14m, ce_7m, ce_phi0_rise, ce_phi1_rise, phi0, q3;
    logic [6:0] hcount;

    fuji_timing_generator #(
        .ACC_WIDTH      (ACC_WIDTH),
        .PHASE_INC      (ACC_WIDTH'(PHASE_INC)),
        .CYCLES_PER_LINE(CPL)
    ) dut (
        .clk_core    (clk_core),
        .reset       (reset),
        .speed       (speed),
        .ce_14m      (ce_14m),
        .ce_7m       (ce_7m),
        .ce_phi0_rise(ce_phi0_rise),
        .ce_phi1_rise(ce_phi1_rise),
        .phi0        (phi0),
        .q3          (q3),
        .hcount      (hcount)
    );

    always #5 clk_core = ~clk_core;

    typedef struct packed {
        logic       phi0;
        logic       q3;
        logic       ce7;
        logic       p0r;
        logic       p1r;
        logic [6:0] hc;
        logic [3:0] tick;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt14 = 0;
    int   cnt_p0r = 0;
    bit   free_run = 0;
    bit   prev14 = 0;

    // Hand-written per-tick tables: bit n is the level at tick n.
    logic [15:0] phi0_tab = 16'b0000_0000_0111_1111;
    logic [15:0] q3_tab   = 16'b0000_0111_1000_1111;
    int   exp_tick = 0;
    int   exp_hc = 0;

    always @(negedge clk_core) begin
        if (ce_14m) begin
            exp_t e;
            cnt14++;
            if (ce_phi0_rise) cnt_p0r++;
            checks++;
            if (prev14) begin
                errors++;
                $display("FAIL adjacent_ce14 got two consecutive pulses want isolated pulses");
            end
            if (!free_run) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tick got ce_14m want none (hcount %0d)", hcount);
                end else begin
                    e = sb_q.pop_front();
                    if ({phi0, q3, ce_7m, ce_phi0_rise, ce_phi1_rise, hcount} !==
                        {e.phi0, e.q3, e.ce7, e.p0r, e.p1r, e.hc}) begin
                        errors++;
                        $display("FAIL tick%0d got phi0=%b q3=%b 7m=%b p0r=%b p1r=%b hc=%0d want phi0=%b q3=%b 7m=%b p0r=%b p1r=%b hc=%0d",
                                 e.tick, phi0, q3, ce_7m, ce_phi0_rise, ce_phi1_rise, hcount,
                                 e.phi0, e.q3, e.ce7, e.p0r, e.p1r, e.hc);
                    end else begin
                        $display("tick %0d ok phi0=%b q3=%b hc=%0d", e.tick, phi0, q3, hcount);
                    end
                end
            end
        end else begin
            checks++;
            if (ce_7m | ce_phi0_rise | ce_phi1_rise) begin
                errors++;
                $display("FAIL stray_ce got 7m=%b p0r=%b p1r=%b without ce_14m want 000",
                         ce_7m, ce_phi0_rise, ce_phi1_rise);
            end
        end
        prev14 = ce_14m;
    end

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end else begin
            $display("check %s ok value %0d", name, got);
        end
    endtask

    task automatic push_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int last;
            exp_t e;
            last = 13;
`ifdef FUJI_TIMING_STRETCH_EN
            if (exp_hc == CPL - 1) last = 15;
`endif
            if (exp_tick == last) begin
                exp_tick = 0;
                exp_hc   = (exp_hc == CPL - 1) ? 0 : exp_hc + 1;
            end else begin
                exp_tick = exp_tick + 1;
            end
            e.tick = 4'(exp_tick);
            e.phi0 = phi0_tab[exp_tick];
            e.q3   = q3_tab[exp_tick];
            e.ce7  = (exp_tick % 2) == 0;
            e.p0r  = (exp_tick == 0);
            e.p1r  = (exp_tick == 7);
            e.hc   = 7'(exp_hc);
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int b;
        b = budget;
        while (sb_q.size() != 0 && b > 0) begin
            @(negedge clk_core);
            #1;
            b--;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d pending ticks want 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        int b14, bp;
        longint n;
        reset = 1'b1;
        speed = 2'b00;
        repeat (3) @(posedge clk_core);
        @(negedge clk_core);
        chk("reset_state", {ce_14m, ce_7m, ce_phi0_rise, ce_phi1_rise, phi0, q3, hcount},
            {4'b0000, 1'b1, 1'b1, 7'd0});
        #1 reset = 1'b0;

        // One full line at normal speed.
        b14 = cnt14;
        bp  = cnt_p0r;
        push_ticks(LINE_TICKS);
        drain("line", 8000);
        chk("line_ce14", cnt14 - b14, LINE_TICKS);
        chk("line_phi0_rise", cnt_p0r - bp, CPL);

        // Pause at tick 5, then resume.
        push_ticks(5);
        drain("to_tick5", 100);
        speed = 2'b10;
        b14 = cnt14;
        repeat (1000) @(negedge clk_core);
        #1;
        chk("pause_ce14", cnt14 - b14, 0);
        chk("pause_hold", {phi0, q3, hcount}, {1'b1, 1'b0, 7'd0});
        speed = 2'b00;
        push_ticks(9);
        drain("resume", 200);

        // Double speed.
        speed = 2'b01;
        push_ticks(28);
        drain("double", 200);
        speed = 2'b00;

        // Reset mid-cycle at tick 12.
        push_ticks(12);
        drain("to_tick12", 200);
        reset = 1'b1;
        @(negedge clk_core);
        chk("midreset_state", {ce_14m, ce_7m, ce_phi0_rise, ce_phi1_rise, phi0, q3, hcount},
            {4'b0000, 1'b1, 1'b1, 7'd0});
        exp_tick = 0;
        exp_hc   = 0;
        #1 reset = 1'b0;
        push_ticks(3);
        drain("after_reset", 100);

        // Long-run tick rates from a cleared accumulator.
        free_run = 1;
        n = 10000;
        reset = 1'b1;
        @(negedge clk_core);
        #1 reset = 1'b0;
        b14 = cnt14;
        repeat (int'(n)) @(negedge clk_core);
        #1;
        chk("rate_normal", cnt14 - b14, (n * PHASE_INC) >> 32);

        reset = 1'b1;
        @(negedge clk_core);
        #1 reset = 1'b0;
        speed = 2'b01;
        b14 = cnt14;
        repeat (int'(n)) @(negedge clk_core);
        #1;
        chk("rate_double", cnt14 - b14, (n * 2 * PHASE_INC) >> 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
